// File: rtl/sigma_delta_dac_mc.sv
// sigma_delta_dac_mc
// Multi-channel first-order sigma-delta DAC. Each channel holds a captured
// PCM sample, slews a working value toward it (or toward midscale while
// muted) and feeds that working value into a carry-out modulator.
// Channels share only the ramp prescaler and the dither LFSR.
module sigma_delta_dac_mc #(
    parameter int CHANNELS  = 2,
    parameter int WIDTH     = 16,
    parameter int SIGNED    = 1,
    parameter int RAMP_DIV  = 64,
    parameter int RAMP_STEP = 16,
    parameter int DITHER    = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic                      din_valid,
    output logic                      din_ready,
    input  logic                      mute,
    output logic                      ramp_busy,
    output logic [CHANNELS-1:0]       dout
);
    localparam logic [WIDTH-1:0] MID  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam int               PW   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [WIDTH:0]   STEP = (WIDTH+1)'(RAMP_STEP);

    logic                din_ready_reg;
    logic                ramp_busy_reg;
    logic                tick;
    logic                capture;
    logic [WIDTH:0]      dith;
    logic [CHANNELS-1:0] differ;
    logic [CHANNELS-1:0] dout_bits;

    assign capture   = din_valid & din_ready_reg;
    assign din_ready = din_ready_reg;
    assign ramp_busy = ramp_busy_reg;
    assign dout      = dout_bits;

    // Ready comes up on the first edge after reset release and stays up.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            din_ready_reg <= 1'b0;
        end else begin
            din_ready_reg <= 1'b1;
        end
    end

    // Busy reflects last cycle's "some channel still off target" condition.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ramp_busy_reg <= 1'b0;
        end else begin
            ramp_busy_reg <= |differ;
        end
    end

    generate
        if (RAMP_DIV > 0) begin : g_pre
            localparam logic [PW-1:0] PRE_LAST = PW'(RAMP_DIV - 1);
            logic [PW-1:0] pre_reg;

            assign tick = (pre_reg == PRE_LAST);

            // Shared ramp prescaler: counts 0..RAMP_DIV-1, tick on wrap.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    pre_reg <= '0;
                end else if (tick) begin
                    pre_reg <= '0;
                end else begin
                    pre_reg <= pre_reg + PW'(1);
                end
            end
        end else begin : g_nopre
            assign tick = 1'b1;
        end

        if (DITHER > 0) begin : g_dith
            logic [15:0] lfsr_reg;

            assign dith = (WIDTH+1)'(lfsr_reg[DITHER-1:0]);

            // Shared 16-bit Galois LFSR (taps 0xB400), free-running.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    lfsr_reg <= 16'h0001;
                end else begin
                    lfsr_reg <= (lfsr_reg >> 1) ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);
                end
            end
        end else begin : g_nodith
            assign dith = '0;
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [WIDTH-1:0] held_reg;
            logic [WIDTH-1:0] cur_reg;
            logic [WIDTH-1:0] cur_next;
            logic [WIDTH-1:0] tgt;
            logic [WIDTH-1:0] cap;
            logic [WIDTH:0]   acc_reg;
            logic [WIDTH:0]   acc_next;
            logic [WIDTH:0]   gap_up;
            logic [WIDTH:0]   gap_dn;
            logic             dout_reg;

            // Two's-complement input becomes offset-binary by flipping the MSB.
            if (SIGNED != 0) begin : g_signed
                assign cap = {~din[gi*WIDTH + WIDTH - 1], din[gi*WIDTH +: WIDTH-1]};
            end else begin : g_unsigned
                assign cap = din[gi*WIDTH +: WIDTH];
            end

            assign tgt           = mute ? MID : held_reg;
            assign differ[gi]    = (cur_reg != tgt);
            assign dout_bits[gi] = dout_reg;
            assign gap_up        = {1'b0, tgt} - {1'b0, cur_reg};
            assign gap_dn        = {1'b0, cur_reg} - {1'b0, tgt};
            assign acc_next      = {1'b0, acc_reg[WIDTH-1:0]} + {1'b0, cur_reg} + dith;

            // Slew toward the target by at most STEP per tick, landing exactly on it.
            always_comb begin
                cur_next = cur_reg;
                if (RAMP_DIV == 0) begin
                    cur_next = tgt;
                end else if (tick) begin
                    if (tgt > cur_reg) begin
                        cur_next = (gap_up > STEP) ? cur_reg + STEP[WIDTH-1:0] : tgt;
                    end else if (cur_reg > tgt) begin
                        cur_next = (gap_dn > STEP) ? cur_reg - STEP[WIDTH-1:0] : tgt;
                    end
                end
            end

            // Per-channel state: sample hold, working value and modulator.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    held_reg <= MID;
                    cur_reg  <= MID;
                    acc_reg  <= '0;
                    dout_reg <= 1'b0;
                end else begin
                    if (capture) begin
                        held_reg <= cap;
                    end
                    cur_reg  <= cur_next;
                    acc_reg  <= acc_next;
                    dout_reg <= acc_next[WIDTH];
                end
            end
        end
    endgenerate

endmodule

// File: doc/sigma_delta_dac_mc.md
Name: sigma_delta_dac_mc

Overview:
- Multi-channel first-order sigma-delta audio DAC driving the board's 1-bit AUDIO outputs from core PCM samples.
- Generalises the fixed stereo 16-bit path: channel count and sample width are parameters, and input can be signed or unsigned.
- Adds mute with a click-free ramp to midscale and optional LFSR dither.
- Sits between the guest core's DAC_L/DAC_R-style sample buses and the top-level pins.

Parameters:
- CHANNELS, 2, number of independent audio channels (1..8).
- WIDTH, 16, sample width per channel (8..24).
- SIGNED, 1, 1 = two's-complement input (MSB inverted to offset-binary), 0 = unsigned offset-binary input.
- RAMP_DIV, 64, clocks per ramp tick; 0 = ramp disabled.
- RAMP_STEP, 16, maximum per-tick change of the working value, in LSBs.
- DITHER, 0, number of LFSR bits added to the accumulator LSBs (0 = no dither, max 4).

Ports:
- clk  in  1  system clock, e.g. the 27 MHz-derived core clock.
- reset_n  in  1  synchronous active-low reset.
- din  in  CHANNELS*WIDTH  packed samples, channel 0 in the LSBs.
- din_valid  in  1  capture strobe for din.
- din_ready  out  1  high whenever the block can capture din.
- mute  in  1  level; ramps all channels to midscale.
- ramp_busy  out  1  high while any channel's working value differs from its target.
- dout  out  CHANNELS  1-bit sigma-delta outputs, bit n = channel n.

Behaviour:
- Reset (reset_n low at a clk edge): dout = 0, din_ready = 0, ramp_busy = 0, accumulators = 0, held samples = MID, working values = MID, prescaler = 0, LFSR = 1.
- MID = 1 << (WIDTH-1) in offset-binary.
- din_ready is 1 on the first edge after reset release and stays 1; din is captured on any edge with din_valid & din_ready.
- Capture: held[n] <= din slice n, with the MSB inverted when SIGNED = 1. A new capture overrides a previous one, including mid-ramp.
- Target: tgt[n] = mute ? MID : held[n].
- Working value with RAMP_DIV = 0: cur[n] <= tgt[n] every clock.
- Working value with RAMP_DIV > 0:
  - The prescaler counts 0..RAMP_DIV-1 and wraps.
  - On wrap, each channel moves toward its target: cur += min(RAMP_STEP, tgt-cur) or cur -= min(RAMP_STEP, cur-tgt).
  - Never overshoot; compute in unsigned WIDTH+1 bits.
- Modulator, per channel:
  - acc is WIDTH+1 bits; acc <= {1'b0, acc[WIDTH-1:0]} + cur + dith; dout[n] <= acc[WIDTH] of the new sum.
  - dith = LFSR[DITHER-1:0] when DITHER > 0, otherwise 0. The LFSR is a 16-bit Galois LFSR with taps 0xB400, shared by all channels, and advances every clock.
  - Carry into bit WIDTH is the output pulse, then discarded.
- Latency (RAMP_DIV = 0): din captured at edge E, cur updated at E+1, dout first reflects the new value at E+2.
- Density: with DITHER = 0 and the accumulator starting at 0, exactly cur ones occur per 2^WIDTH clocks. cur = 0 gives constant 0. The maximum value 2^WIDTH-1 gives one zero per 2^WIDTH clocks.
- ramp_busy is registered: high the cycle after any cur != tgt, low the cycle after all match. With RAMP_DIV = 0 it pulses one cycle on a change.
- Mute release ramps from MID back to held[n] at the same rate.
- Reset mid-ramp or mid-capture: everything returns to reset values on that edge; no partial state survives.
- Channels are fully independent except for the shared prescaler and the shared LFSR.

Test Plan:
- Reset, then CHANNELS=2, WIDTH=8, SIGNED=0, RAMP_DIV=0; din={8'd0,8'd64}, one valid pulse -> ch0 exactly 64 ones and ch1 0 ones in every 256-clock window after settling; dout first changes at E+2.
- SIGNED=1, WIDTH=16, din ch0=16'h8000, ch1=16'h0000 -> ch0 cur=0 (dout stuck 0); ch1 cur=0x8000, dout toggles 1/0 every clock.
- RAMP_DIV=4, RAMP_STEP=16, WIDTH=8, held=200, assert mute -> cur steps 200,184,...,136,128, one step every 4 clocks (final step 8, no overshoot); ramp_busy high throughout, low one cycle after cur reaches 128.
- During that ramp, capture din=100 and deassert mute at the same edge -> ramp redirects toward 100 from the current value; no glitch beyond RAMP_STEP.
- Assert reset_n=0 for one clock mid-ramp -> next cycle dout=0, ramp_busy=0, cur=MID, din_ready=0, then 1.
- DITHER=2, cur=MID -> long-run ones density 0.5±1% over 2^16 clocks; the pattern is no longer strictly periodic.
